// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer behind the UART core: {err,data} entries, level/almost-full/overflow status.
// Optional character timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2    = 3,
  parameter int AFULL_LVL     = 6,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk16,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_err,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  rd_err,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  timeout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AFULL_THR = (DEPTH_LOG2 + 1)'(AFULL_LVL);

  logic [8:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic                  overflow_r;
  logic                  push_s;
  logic                  pop_s;
  logic                  drop_s;
  logic [8:0]            head_s;

  // A full FIFO still accepts a character when a pop frees a slot in the same cycle.
  assign pop_s  = rd_en && !empty;
  assign push_s = rx_valid && (!full || rd_en);
  assign drop_s = rx_valid && full && !rd_en;

  assign empty       = (level_r == {(DEPTH_LOG2 + 1){1'b0}});
  assign full        = (level_r == DEPTH_LVL);
  assign almost_full = (level_r >= AFULL_THR);
  assign level       = level_r;
  assign overflow    = overflow_r;

  assign head_s  = mem_r[rd_ptr_r];
  assign rd_data = empty ? 8'h00 : head_s[7:0];
  assign rd_err  = empty ? 1'b0  : head_s[8];

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= {rx_err, rx_data};
    end
  end

  // Pointers and level counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      level_r  <= {(DEPTH_LOG2 + 1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{DEPTH_LOG2{1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [9:0] TICK_LAST = 10'(TIMEOUT_TICKS - 1);

  logic [9:0] tick_cnt_r;
  logic       timeout_r;

  // Idle-tick counter; freezes once the flag is raised until the next push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r <= 10'd0;
      timeout_r  <= 1'b0;
    end else if (push_s || pop_s) begin
      tick_cnt_r <= 10'd0;
      timeout_r  <= 1'b0;
    end else if (empty) begin
      tick_cnt_r <= 10'd0;
    end else if (clk16 && !timeout_r) begin
      if (tick_cnt_r == TICK_LAST) begin
        timeout_r <= 1'b1;
      end else begin
        tick_cnt_r <= tick_cnt_r + 10'd1;
      end
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  assign timeout = timeout_r;
`else
  logic unused_tick_s;
  assign unused_tick_s = &{1'b0, clk16, TIMEOUT_TICKS[0]};
  assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences and a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DL    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int TT    = 640;

  logic        clk = 1'b0;
  logic        rst, clk16, rx_valid, rx_err, rd_en, ovf_clr;
  logic [7:0]  rx_data, rd_data;
  logic        rd_err, empty, full, almost_full, overflow, timeout;
  logic [DL:0] level;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH_LOG2(DL), .AFULL_LVL(AF), .TIMEOUT_TICKS(TT)) dut (
    .clk(clk), .rst(rst), .clk16(clk16), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
    .empty(empty), .full(full), .level(level), .almost_full(almost_full),
    .overflow(overflow), .ovf_clr(ovf_clr), .timeout(timeout)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a queue of {err,data}, sticky overflow, idle strobe count.
  logic [8:0] mq[$];
  bit         m_ovf;
  int         m_idle;
  bit         m_to;

  typedef struct {
    bit       valid;
    bit [7:0] data;
    bit       rd;
    bit       clr;
    int       e_level;
    bit [7:0] e_data;
    bit       e_empty;
    bit       e_full;
    bit       e_afull;
    bit       e_ovf;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit pop, push, was_empty;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_idle = 0; m_to = 0;
    end else begin
      was_empty = (mq.size() == 0);
      pop  = rd_en && !was_empty;
      push = rx_valid && (mq.size() < DEPTH || pop);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({rx_err, rx_data});
      if (rx_valid && !push) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (push || pop) begin
        m_idle = 0; m_to = 0;
      end else if (was_empty) begin
        m_idle = 0;
      end else if (clk16 && !m_to) begin
        m_idle++;
        if (m_idle == TT) m_to = 1;
      end
    end
  endtask

  task automatic check_model();
    int sz;
    logic [8:0] hd;
    sz = mq.size();
    hd = (sz == 0) ? 9'h000 : mq[0];
    chk("level", 32'(level), 32'(sz));
    chk("rd_data", 32'(rd_data), 32'(hd[7:0]));
    chk("rd_err", 32'(rd_err), 32'(hd[8]));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(sz >= AF));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_TIMEOUT_EN
    chk("timeout", 32'(timeout), 32'(m_to));
`else
    chk("timeout", 32'(timeout), 32'd0);
`endif
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_in();
    rst = 1'b0; clk16 = 1'b0; rx_valid = 1'b0; rx_err = 1'b0;
    rx_data = 8'h00; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    rx_valid = 1'b1; rx_data = d; rx_err = e;
    cycle();
    idle_in();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    cycle();
    idle_in();
  endtask

  initial begin
    // Vector table: fill 0..7, overflow with 0xFF, drain, then clear overflow.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 8'(i), 1'b0, 1'b0, i + 1, 8'h00, 1'b0, (i == 7), (i + 1 >= AF), 1'b0};
    tbl[8] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 1; k <= 8; k++)
      tbl[8 + k] = '{1'b0, 8'h00, 1'b1, 1'b0, 8 - k, (k < 8) ? 8'(k) : 8'h00,
                     (k == 8), 1'b0, (8 - k >= AF), 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

    idle_in();
    rst = 1'b1;
    cycle();
    cycle();
    idle_in();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);

    // Three spaced characters, then read them back in order.
    push(8'h41, 1'b0); repeat (19) cycle();
    push(8'h42, 1'b0); repeat (19) cycle();
    push(8'h43, 1'b0); repeat (19) cycle();
    chk("seq_level3", 32'(level), 32'd3);
    chk("seq_head41", 32'(rd_data), 32'h41);
    pop(); chk("seq_head42", 32'(rd_data), 32'h42);
    pop(); chk("seq_head43", 32'(rd_data), 32'h43);
    pop(); chk("seq_empty", 32'(empty), 32'd1);
    chk("seq_rd_zero", 32'(rd_data), 32'd0);

    foreach (tbl[i]) begin
      rx_valid = tbl[i].valid; rx_data = tbl[i].data;
      rd_en = tbl[i].rd; ovf_clr = tbl[i].clr;
      cycle();
      idle_in();
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].e_level));
      chk($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].e_full));
      chk($sformatf("tbl%0d_afull", i), 32'(almost_full), 32'(tbl[i].e_afull));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
    end

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b0);
    rx_valid = 1'b1; rx_data = 8'hAA; rd_en = 1'b1;
    cycle();
    idle_in();
    chk("pp_level", 32'(level), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) pop();
    chk("pp_last", 32'(rd_data), 32'hAA);
    pop();

    // Error flag travels with its character.
    push(8'h55, 1'b1);
    push(8'h66, 1'b0);
    chk("err_data55", 32'(rd_data), 32'h55);
    chk("err_flag1", 32'(rd_err), 32'd1);
    pop();
    chk("err_data66", 32'(rd_data), 32'h66);
    chk("err_flag0", 32'(rd_err), 32'd0);
    pop();

    // Pops on empty are ignored; reset mid-stream discards everything incl. a coincident character.
    for (int i = 0; i < 5; i++) pop();
    chk("empty_pop_level", 32'(level), 32'd0);
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 1'b0);
    rx_valid = 1'b1; rx_data = 8'hEE; rst = 1'b1;
    cycle();
    idle_in();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Character timeout after TT idle strobes.
    push(8'h77, 1'b0);
    clk16 = 1'b1;
    for (int i = 0; i < TT - 1; i++) cycle();
    chk("to_before", 32'(timeout), 32'd0);
    cycle();
`ifdef UART_RX_TIMEOUT_EN
    chk("to_set", 32'(timeout), 32'd1);
`else
    chk("to_off", 32'(timeout), 32'd0);
`endif
    repeat (5) cycle();
    idle_in();
    pop();
    chk("to_clear", 32'(timeout), 32'd0);

    // Randomised traffic against the model, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 3000; i++) begin
      bit fill;
      fill     = ((i / 200) % 2) == 0;
      rst      = ($urandom_range(0, 299) == 0);
      clk16    = $urandom_range(0, 1) == 1;
      rx_valid = fill ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      rd_en    = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      rx_data  = 8'($urandom);
      rx_err   = $urandom_range(0, 7) == 0;
      ovf_clr  = $urandom_range(0, 15) == 0;
      cycle();
    end
    idle_in();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
